// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: 2-entry skid buffer with a valid/ready handshake,
// flush-to-NOP and a saturating downstream bubble counter.
module pipe_stage_buf #(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  // Handshake: a beat moves on a port only in a cycle where valid and ready are
  // both 1 at the rising edge; a producer holds valid and data stable until then.

  // Encoding equals the entry count, so occupancy_o doubles as the state debug view.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   m_q, m_d;
  logic [DATA_W-1:0]   s_q, s_d;
  logic [CNT_W-1:0]    bubble_q, bubble_d;
  logic                acc, pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      m_q      <= NOP_VALUE;
      s_q      <= NOP_VALUE;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      s_q      <= s_d;
      bubble_q <= bubble_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    acc     = in_valid_i & in_ready_o;
    pop     = out_valid_o & out_ready_i;
    if (flush_i) begin
      // A pop in this cycle already completed downstream; nothing is re-presented.
      state_d = ST_EMPTY;
      m_d     = NOP_VALUE;
      s_d     = NOP_VALUE;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            m_d     = in_data_i;
            state_d = ST_HALF;
          end
        end
        ST_HALF: begin
          if (acc && pop) begin
            m_d = in_data_i;
          end else if (acc) begin
            s_d     = in_data_i;
            state_d = ST_FULL;
          end else if (pop) begin
            m_d     = NOP_VALUE;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            m_d     = s_q;
            s_d     = NOP_VALUE;
            state_d = ST_HALF;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          m_d     = NOP_VALUE;
          s_d     = NOP_VALUE;
        end
      endcase
    end
  end

  // Bubble: downstream was ready but had nothing to take; flush cycles are excluded.
  always_comb begin
    bubble_d = bubble_q;
    if (out_ready_i && !out_valid_o && !flush_i && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    out_valid_o  = (state_q != ST_EMPTY);
    in_ready_o   = (state_q != ST_FULL);
    occupancy_o  = state_q;
    out_data_o   = m_q;
    bubble_cnt_o = bubble_q;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios followed by a random
// soak, all compared each cycle against a queue-based model of the buffer.
module tb_pipe_stage_buf;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int BUB_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [1:0]        occupancy_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  pipe_stage_buf #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .occupancy_o  (occupancy_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  always #5 clk = ~clk;

  // Model: the held entries in FIFO order, plus the bubble count.
  logic [DATA_W-1:0] exp_q[$];
  int                exp_bub;
  bit                last_acc;
  bit                last_kill;
  int                checks;
  int                errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = exp_q.size();
    check("out_valid", 64'(out_valid_o), 64'(n > 0));
    check("in_ready", 64'(in_ready_o), 64'(n < 2));
    check("occupancy", 64'(occupancy_o), 64'(n));
    check("out_data", 64'(out_data_o), (n > 0) ? 64'(exp_q[0]) : 64'(0));
    check("bubble_cnt", 64'(bubble_cnt_o), 64'(exp_bub));
  endtask

  // Advance one clock and apply the buffer's rules to the model.
  task automatic step();
    int n;
    bit acc, pop;
    @(posedge clk);
    n = exp_q.size();
    last_acc  = 1'b0;
    last_kill = rst || flush_i;
    if (rst) begin
      exp_q.delete();
      exp_bub = 0;
    end else if (flush_i) begin
      exp_q.delete();
    end else begin
      acc = in_valid_i && (n < 2);
      pop = (n > 0) && out_ready_i;
      if ((n == 0) && out_ready_i && (exp_bub < BUB_MAX)) exp_bub++;
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(in_data_i);
      last_acc = acc;
    end
    #1;
    check_outputs();
  endtask

  // Drive one cycle of inputs, confirm outputs did not react combinationally, clock.
  task automatic drive(input bit r, input bit f, input bit v, input logic [DATA_W-1:0] d,
                       input bit o);
    rst         = r;
    flush_i     = f;
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = o;
    #1;
    check("ready_no_comb", 64'(in_ready_o), 64'(exp_q.size() < 2));
    check("valid_no_comb", 64'(out_valid_o), 64'(exp_q.size() > 0));
    step();
  endtask

  initial begin
    bit                v, f, o;
    logic [DATA_W-1:0] d;
    checks  = 0;
    errors  = 0;
    exp_bub = 0;
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;

    // Reset then streaming
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check("reset_ready", 64'(in_ready_o), 64'(1));
    check("reset_occ", 64'(occupancy_o), 64'(0));
    drive(0, 0, 1, 32'h1, 1);
    check("stream_1", 64'(out_data_o), 64'h1);
    drive(0, 0, 1, 32'h2, 1);
    check("stream_2", 64'(out_data_o), 64'h2);
    drive(0, 0, 1, 32'h3, 1);
    check("stream_3", 64'(out_data_o), 64'h3);
    check("stream_occ", 64'(occupancy_o), 64'(1));
    drive(0, 0, 0, 0, 1);

    // Backpressure / skid
    drive(0, 0, 1, 32'hA, 0);
    drive(0, 0, 1, 32'hB, 0);
    check("skid_occ", 64'(occupancy_o), 64'(2));
    check("skid_ready", 64'(in_ready_o), 64'(0));
    drive(0, 0, 1, 32'hC, 0);
    check("skid_hold_a", 64'(out_data_o), 64'hA);
    drive(0, 0, 1, 32'hC, 1);
    check("skid_b", 64'(out_data_o), 64'hB);
    check("skid_ready_back", 64'(in_ready_o), 64'(1));
    drive(0, 0, 1, 32'hC, 1);
    check("skid_c", 64'(out_data_o), 64'hC);
    drive(0, 0, 0, 0, 1);

    // Flush while full, with a dropped input
    drive(0, 0, 1, 32'h11, 0);
    drive(0, 0, 1, 32'h12, 0);
    drive(0, 1, 1, 32'hD, 0);
    check("flush_valid", 64'(out_valid_o), 64'(0));
    check("flush_data", 64'(out_data_o), 64'h0);
    check("flush_ready", 64'(in_ready_o), 64'(1));
    drive(0, 0, 0, 0, 1);
    check("flush_no_d", 64'(out_valid_o), 64'(0));

    // Simultaneous accept and pop while half full
    drive(0, 0, 1, 32'h5, 0);
    drive(0, 0, 1, 32'h6, 1);
    check("accpop_occ", 64'(occupancy_o), 64'(1));
    check("accpop_data", 64'(out_data_o), 64'h6);
    drive(0, 0, 0, 0, 1);

    // Bubble counter saturation, flush, reset
    drive(1, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 1);
    check("bubble_sat", 64'(bubble_cnt_o), 64'(BUB_MAX));
    drive(0, 1, 0, 0, 1);
    check("bubble_flush_keep", 64'(bubble_cnt_o), 64'(BUB_MAX));
    drive(1, 0, 0, 0, 1);
    check("bubble_rst", 64'(bubble_cnt_o), 64'(0));

    // Random soak; an offered beat is held until accepted or killed
    v = 1'b0; d = '0;
    last_acc = 1'b0; last_kill = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!v || last_acc || last_kill) begin
        v = ($urandom_range(0, 1) == 1);
        d = $urandom;
      end
      f = ($urandom_range(0, 99) < 5);
      o = ($urandom_range(0, 2) != 0);
      drive(0, f, v, d, o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
